// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS32 controller: states, opcodes/functs,
// ALU operation codes, datapath mux selects and the decoded-instruction record.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J
    } iclass_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_NOR = 4'd4, ALU_XOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20,
                           FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25,
                           FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A;

    localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2;
    localparam logic [1:0] SRCB_RT = 2'd0, SRCB_IMM = 2'd1, SRCB_SHAMT = 2'd2;

    typedef struct packed {
        iclass_e    cls;
        alu_op_e    alu_op;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/mips_decode.sv
// Combinational opcode/funct decoder: instruction class, ALU control,
// operand-B select, destination select and a legality flag.
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '{cls: C_RTYPE, alu_op: ALU_ADD, alu_src_b: SRCB_RT,
                  reg_dst: 1'b0, legal: 1'b1};
        case (opcode_i)
            OP_RTYPE: begin
                dec_o.reg_dst = 1'b1;
                case (funct_i)
                    FN_ADD: dec_o.alu_op = ALU_ADD;
                    FN_SUB: dec_o.alu_op = ALU_SUB;
                    FN_AND: dec_o.alu_op = ALU_AND;
                    FN_OR:  dec_o.alu_op = ALU_OR;
                    FN_NOR: dec_o.alu_op = ALU_NOR;
                    FN_XOR: dec_o.alu_op = ALU_XOR;
                    FN_SLT: dec_o.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec_o.alu_op    = ALU_SLL;
                        dec_o.alu_src_b = SRCB_SHAMT;
                    end
                    FN_SRL: begin
                        dec_o.alu_op    = ALU_SRL;
                        dec_o.alu_src_b = SRCB_SHAMT;
                    end
                    default: dec_o.legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                dec_o.cls       = C_IMM;
                dec_o.alu_src_b = SRCB_IMM;
                dec_o.alu_op    = (opcode_i == OP_ANDI) ? ALU_AND :
                                  (opcode_i == OP_ORI)  ? ALU_OR  :
                                  (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            OP_LW: begin
                dec_o.cls       = C_LW;
                dec_o.alu_src_b = SRCB_IMM;
            end
            OP_SW: begin
                dec_o.cls       = C_SW;
                dec_o.alu_src_b = SRCB_IMM;
            end
            OP_BEQ: begin
                dec_o.cls    = C_BEQ;
                dec_o.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec_o.cls    = C_BNE;
                dec_o.alu_op = ALU_SUB;
            end
            OP_J:    dec_o.cls   = C_J;
            default: dec_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control FSM with memory handshakes and ack timeout.
// Build option SINGLE_STEP_EN adds a 'step' input that gates each instruction fetch.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLOCK_50,
    input  logic             reset,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             abort_q, abort_d;
    dec_t             dec_q, dec_d, dec_w;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             timeout;
    logic             run_ok;

    mips_decode u_dec (
        .opcode_i (opcode),
        .funct_i  (funct),
        .dec_o    (dec_w)
    );

    assign timeout = (wait_q == 8'(ACK_TIMEOUT - 1));

`ifdef SINGLE_STEP_EN
    logic step_q, step_prev_q, go_q;

    // A step edge arms one fetch; the arm is consumed when the IR loads.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            go_q        <= 1'b0;
        end else begin
            step_q      <= step;
            step_prev_q <= step_q;
            if (ir_write)
                go_q <= 1'b0;
            else if (step_q && !step_prev_q)
                go_q <= 1'b1;
        end
    end

    assign run_ok = go_q;
`else
    assign run_ok = 1'b1;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            abort_q   <= 1'b0;
            dec_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            abort_q   <= abort_d;
            dec_q     <= dec_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        abort_d    = 1'b0;
        dec_d      = dec_q;
        illegal_d  = illegal_q;
        mem_err_d  = mem_err_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        alu_op     = ALU_ADD;
        alu_src_b  = SRCB_RT;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        // Outputs stay quiet while reset is held so nothing leaks to memory.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    if (abort_q || !run_ok) begin
                        wait_d = '0;
                    end else begin
                        imem_req = 1'b1;
                        if (imem_ack) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                            wait_d   = '0;
                            state_d  = S_DECODE;
                        end else if (timeout) begin
                            mem_err_d = 1'b1;
                            abort_d   = 1'b1;
                            wait_d    = '0;
                        end else begin
                            wait_d = wait_q + 8'd1;
                        end
                    end
                end
                S_DECODE: begin
                    dec_d = dec_w;
                    if (dec_w.legal) begin
                        state_d = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_op    = dec_q.alu_op;
                    alu_src_b = dec_q.alu_src_b;
                    case (dec_q.cls)
                        C_LW, C_SW: state_d = S_MEM;
                        C_BEQ, C_BNE, C_J: begin
                            pc_write  = (dec_q.cls == C_J)   ? 1'b1 :
                                        (dec_q.cls == C_BEQ) ? alu_zero : !alu_zero;
                            pc_src    = (dec_q.cls == C_J) ? PC_JMP : PC_BR;
                            retired_d = retired_q + CNT_W'(1);
                            state_d   = S_FETCH;
                        end
                        default: state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (dec_q.cls == C_SW);
                    if (dmem_ack) begin
                        wait_d = '0;
                        if (dec_q.cls == C_LW) begin
                            state_d = S_WB;
                        end else begin
                            retired_d = retired_q + CNT_W'(1);
                            state_d   = S_FETCH;
                        end
                    end else if (timeout) begin
                        mem_err_d = 1'b1;
                        wait_d    = '0;
                        state_d   = S_FETCH;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = dec_q.reg_dst;
                    mem_to_reg = (dec_q.cls == C_LW);
                    retired_d  = retired_q + CNT_W'(1);
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, cycle-by-cycle vector bench for mips_multicycle_ctrl (default build).
module tb_mips_multicycle_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0, funct = '0;
    logic        alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg;
    logic [2:0]  state;
    logic        illegal, mem_err;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;

    mips_multicycle_ctrl #(.ACK_TIMEOUT(16), .CNT_W(32)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .alu_src_b  (alu_src_b),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .illegal    (illegal),
        .mem_err    (mem_err),
        .retired    (retired)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Control-output vector: {imem_req,dmem_req,dmem_we,ir_write,pc_write,
    // pc_src[1:0],alu_op[3:0],alu_src_b[1:0],reg_write,reg_dst,mem_to_reg}
    logic [15:0] act_ctl;
    assign act_ctl = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                      alu_op, alu_src_b, reg_write, reg_dst, mem_to_reg};

    localparam logic [15:0] IREQ = 16'h8000, DREQ = 16'h4000, WE  = 16'h2000,
                            IRW  = 16'h1000, PCW  = 16'h0800, PS1 = 16'h0200,
                            PS2  = 16'h0400, SB1  = 16'h0008, SB2 = 16'h0010,
                            RW   = 16'h0004, RD   = 16'h0002, M2R = 16'h0001;
    localparam logic [15:0] FACK = IREQ | IRW | PCW;

    function automatic logic [15:0] aop(input int n);
        return 16'(n << 5);
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op, fn;
        logic        z, ia, da;
        logic [2:0]  st;
        logic [15:0] ctl;
        logic        ill, merr;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    task automatic r(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ia, input logic da,
                     input logic [2:0] st, input logic [15:0] ctl,
                     input logic ill, input logic merr, input int ret);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.ia = ia; v.da = da;
        v.st = st; v.ctl = ctl; v.ill = ill; v.merr = merr; v.ret = 32'(ret);
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, compare mid-cycle, then advance past the edge.
    task automatic cyc(input string name, input int idx, input logic rst,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ia, input logic da,
                       input logic [2:0] st, input logic [15:0] ctl,
                       input logic ill, input logic merr, input logic [31:0] ret);
        reset = rst; opcode = op; funct = fn; alu_zero = z;
        imem_ack = ia; dmem_ack = da;
        @(negedge CLOCK_50);
        tests++;
        if (state !== st || act_ctl !== ctl || illegal !== ill ||
            mem_err !== merr || retired !== ret) begin
            fails++;
            $display("FAIL %s[%0d]: got st=%0d ctl=%h ill=%b merr=%b ret=%0d, want st=%0d ctl=%h ill=%b merr=%b ret=%0d",
                     name, idx, state, act_ctl, illegal, mem_err, retired,
                     st, ctl, ill, merr, ret);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add
        r(0, 6'h00, 6'h20, 0, 1, 0, 0, FACK, 0, 0, 0);
        r(0, 6'h00, 6'h20, 0, 0, 1, 1, 0, 0, 0, 0);
        r(0, 6'h00, 6'h20, 0, 0, 0, 2, aop(0), 0, 0, 0);
        r(0, 6'h00, 6'h20, 0, 0, 0, 4, RW | RD, 0, 0, 0);
        // sub
        r(0, 6'h00, 6'h22, 0, 1, 0, 0, FACK, 0, 0, 1);
        r(0, 6'h00, 6'h22, 0, 0, 0, 1, 0, 0, 0, 1);
        r(0, 6'h00, 6'h22, 0, 0, 0, 2, aop(1), 0, 0, 1);
        r(0, 6'h00, 6'h22, 0, 0, 0, 4, RW | RD, 0, 0, 1);
        // ori
        r(0, 6'h0D, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 2);
        r(0, 6'h0D, 6'h00, 0, 0, 0, 1, 0, 0, 0, 2);
        r(0, 6'h0D, 6'h00, 0, 0, 0, 2, aop(3) | SB1, 0, 0, 2);
        r(0, 6'h0D, 6'h00, 0, 0, 0, 4, RW, 0, 0, 2);
        // sll
        r(0, 6'h00, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 3);
        r(0, 6'h00, 6'h00, 0, 0, 0, 1, 0, 0, 0, 3);
        r(0, 6'h00, 6'h00, 0, 0, 0, 2, aop(7) | SB2, 0, 0, 3);
        r(0, 6'h00, 6'h00, 0, 0, 0, 4, RW | RD, 0, 0, 3);
        // lw with dmem_ack on the 4th MEM cycle
        r(0, 6'h23, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 0, 1, 0, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 0, 2, SB1, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 0, 3, DREQ, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 0, 3, DREQ, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 0, 3, DREQ, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 1, 3, DREQ, 0, 0, 4);
        r(0, 6'h23, 6'h00, 0, 0, 0, 4, RW | M2R, 0, 0, 4);
        // sw
        r(0, 6'h2B, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 5);
        r(0, 6'h2B, 6'h00, 0, 0, 0, 1, 0, 0, 0, 5);
        r(0, 6'h2B, 6'h00, 0, 0, 0, 2, SB1, 0, 0, 5);
        r(0, 6'h2B, 6'h00, 0, 0, 1, 3, DREQ | WE, 0, 0, 5);
        // beq taken / not taken
        r(0, 6'h04, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 6);
        r(0, 6'h04, 6'h00, 0, 0, 0, 1, 0, 0, 0, 6);
        r(0, 6'h04, 6'h00, 1, 0, 0, 2, aop(1) | PCW | PS1, 0, 0, 6);
        r(0, 6'h04, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 7);
        r(0, 6'h04, 6'h00, 0, 0, 0, 1, 0, 0, 0, 7);
        r(0, 6'h04, 6'h00, 0, 0, 0, 2, aop(1) | PS1, 0, 0, 7);
        // bne taken / not taken
        r(0, 6'h05, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 8);
        r(0, 6'h05, 6'h00, 0, 0, 0, 1, 0, 0, 0, 8);
        r(0, 6'h05, 6'h00, 0, 0, 0, 2, aop(1) | PCW | PS1, 0, 0, 8);
        r(0, 6'h05, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 9);
        r(0, 6'h05, 6'h00, 0, 0, 0, 1, 0, 0, 0, 9);
        r(0, 6'h05, 6'h00, 1, 0, 0, 2, aop(1) | PS1, 0, 0, 9);
        // j
        r(0, 6'h02, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 10);
        r(0, 6'h02, 6'h00, 0, 0, 0, 1, 0, 0, 0, 10);
        r(0, 6'h02, 6'h00, 0, 0, 0, 2, PCW | PS2, 0, 0, 10);
        // illegal opcode, stray dmem_ack in FETCH ignored
        r(0, 6'h3F, 6'h00, 0, 1, 0, 0, FACK, 0, 0, 11);
        r(0, 6'h3F, 6'h00, 0, 0, 0, 1, 0, 0, 0, 11);
        r(0, 6'h3F, 6'h00, 0, 0, 1, 0, IREQ, 1, 0, 11);
        // reset while lw sits in MEM
        r(0, 6'h23, 6'h00, 0, 1, 0, 0, FACK, 1, 0, 11);
        r(0, 6'h23, 6'h00, 0, 0, 0, 1, 0, 1, 0, 11);
        r(0, 6'h23, 6'h00, 0, 0, 0, 2, SB1, 1, 0, 11);
        r(0, 6'h23, 6'h00, 0, 0, 0, 3, DREQ, 1, 0, 11);
        r(1, 6'h23, 6'h00, 0, 0, 0, 3, 0, 1, 0, 11);
        r(0, 6'h23, 6'h00, 0, 0, 0, 0, IREQ, 0, 0, 0);

        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        foreach (vecs[i])
            cyc("vec", i, vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z,
                vecs[i].ia, vecs[i].da, vecs[i].st, vecs[i].ctl,
                vecs[i].ill, vecs[i].merr, vecs[i].ret);

        // Fetch timeout: 16 request cycles, one dropped cycle, then retry
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc("ftimeout_req", i, 0, 0, 6'h20, 0, 0, 0, 0, IREQ, 0, 0, 0);
        cyc("ftimeout_drop", 0, 0, 0, 6'h20, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
        cyc("ftimeout_retry", 0, 0, 0, 6'h20, 0, 0, 0, 0, IREQ, 0, 1, 0);
        cyc("ftimeout_ack", 0, 0, 0, 6'h20, 0, 1, 0, 0, FACK, 0, 1, 0);
        cyc("ftimeout_dec", 0, 0, 0, 6'h20, 0, 0, 0, 1, 0, 0, 1, 0);

        // Data timeout on sw: instruction abandoned, not retired
        do_reset();
        cyc("mtimeout_f", 0, 0, 6'h2B, 0, 0, 1, 0, 0, FACK, 0, 0, 0);
        cyc("mtimeout_d", 0, 0, 6'h2B, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("mtimeout_e", 0, 0, 6'h2B, 0, 0, 0, 0, 2, SB1, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cyc("mtimeout_mem", i, 0, 6'h2B, 0, 0, 0, 0, 3, DREQ | WE, 0, 0, 0);
        cyc("mtimeout_after", 0, 0, 6'h2B, 0, 0, 0, 0, 0, IREQ, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
